// File: rtl/prach_pkg.sv
// prach_pkg: shared PRACH buffer constants and fill FSM states
package prach_pkg;
  localparam int DEPTH = 1536;
  localparam int AW = 11;
  localparam int IQW = 16;
  typedef enum logic {IDLE, FILL} fill_st_e;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/prach_buffer_channel.sv
// prach_buffer_channel: ping-pong capture of one PRACH occasion per bank with
// a request/grant readout handshake towards a shared reader.
module prach_buffer_channel
  import prach_pkg::*;
#(
  parameter int DEPTH = prach_pkg::DEPTH,
  parameter int AW    = prach_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic [IQW-1:0]   din_dr,
  input  logic [IQW-1:0]   din_di,
  input  logic             din_dv,
  output logic             done_req,
  input  logic             done_ack,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_en,
  output logic [2*IQW-1:0] rd_data,
  output logic             overflow
);
  fill_st_e st_q, st_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [1:0] full_q, full_d;
  logic wb_q, wb_d, rb_q, rb_d, ack_q, rd_en_q, done_req_q, done_req_d, ovf_q, ovf_d;
  logic start, we, last, ack_fall;
  logic [2*IQW-1:0] ram_q;
  assign start    = sync_in & din_dv;
  assign we       = din_dv & ((st_q == FILL) | (start & ~full_q[wb_q]));
  assign last     = we & ~start & (wcnt_q == AW'(DEPTH - 1));
  assign ack_fall = ack_q & ~done_ack;
  always_comb begin
    st_d   = we ? (last ? IDLE : FILL) : st_q;
    wcnt_d = !we ? wcnt_q : last ? '0 : start ? AW'(1) : wcnt_q + 1'b1;
    wb_d   = wb_q ^ last;
    rb_d   = rb_q ^ ack_fall;
    full_d = full_q;
    if (last) full_d[wb_q] = 1'b1;
    if (ack_fall) full_d[rb_q] = 1'b0;
    // request is held off for the whole grant, so it can never overlap the ack fall
    done_req_d = full_d[rb_d] & ~done_ack;
    ovf_d      = start & (st_q == IDLE) & full_q[wb_q];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      wcnt_q     <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      full_q     <= '0;
      ack_q      <= 1'b0;
      done_req_q <= 1'b0;
      ovf_q      <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      wcnt_q     <= wcnt_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      full_q     <= full_d;
      ack_q      <= done_ack;
      done_req_q <= done_req_d;
      ovf_q      <= ovf_d;
      rd_en_q    <= rd_en;
    end
  end
  sdp_ram #(.AW(AW + 1), .DW(2 * IQW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i ({wb_q, start ? AW'(0) : wcnt_q}),
    .wdata_i ({din_di, din_dr}),
    .re_i    (rd_en),
    .raddr_i ({rb_q, rd_addr}),
    .rdata_o (ram_q)
  );
  // zero when idle so several channels can be OR-combined downstream
  assign rd_data  = rd_en_q ? ram_q : '0;
  assign done_req = done_req_q;
  assign overflow = ovf_q;
endmodule
